pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage LEGv8 pipeline (IF/ID/EX/MEM/WB).
- Decodes source registers of the instruction held in IF/ID, using the same format classes as the immediate sign extender: R, I, D, B, CB and LSL.
- Inserts load-use bubbles, flushes on a taken branch resolved in MEM, and freezes the pipeline while data memory is busy.
- Keeps saturating performance counters and a sticky memory-timeout flag.

Parameters:
CNT_W, 16, width of the StallCycles and FlushCount counters
MEM_TIMEOUT, 255, consecutive DMemBusy cycles that set MemTimeout (must be at least 1)
TO_W, 8, width of the internal busy-wait counter (must hold MEM_TIMEOUT)

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  synchronous, active-high reset
InstrID  in  32  instruction in IF/ID register
MemRead_EX  in  1  instruction in ID/EX is a load (LDUR)
Rd_EX  in  5  destination register of ID/EX instruction
BranchTaken_MEM  in  1  branch in EX/MEM resolved taken (B, BL, CBZ or CBNZ)
DMemBusy  in  1  data memory not ready; MEM stage must hold
PCWrite  out  1  PC update enable
IFIDWrite  out  1  IF/ID register load enable
IDEXBubble  out  1  load NOP into ID/EX
PipeHold  out  1  hold ID/EX, EX/MEM and MEM/WB; WB write suppressed
FlushIFID  out  1  zero IF/ID
FlushIDEX  out  1  zero ID/EX
FlushEXMEM  out  1  zero EX/MEM
PCSrc  out  1  1 = PC loads branch target
StallCycles  out  CNT_W  saturating count of stall cycles
FlushCount  out  CNT_W  saturating count of branch flushes
MemTimeout  out  1  sticky timeout flag

Behaviour:
- Source decode on InstrID; unused sources are invalid.
  - R-type (default class): Rn=[9:5], Rm=[20:16].
  - LSL, [31:21]=11010011011: Rn only.
  - LDUR, [31:21]=11111000010: Rn only.
  - STUR, [31:21]=11111000000: Rn and Rt=[4:0].
  - CB, [31:24]=10110100 or 10110101: Rt only.
  - B or BL, [31:26]=000101 or 100101: none.
  - I-type (ADDI/SUBI/ANDI/ORRI families by [31:22]): Rn only.
- Hazard condition: MemRead_EX && Rd_EX!=31 && (Rd_EX equals any valid source). Register 31 (XZR) never hazards.
- FSM states: RUN, LU_STALL, MEM_WAIT. Reset sets RUN.
- Control outputs are combinational from state and inputs. Counters, state and MemTimeout are registered.
- Default outputs: PCWrite=1, IFIDWrite=1, everything else 0.
- Priority, highest first: Reset, DMemBusy, BranchTaken_MEM, load-use.
- DMemBusy=1 (any state):
  - Outputs: PCWrite=0, IFIDWrite=0, PipeHold=1; no flush and no bubble.
  - Next state MEM_WAIT; StallCycles += 1; busy counter += 1 (saturating).
  - If busy counter reaches MEM_TIMEOUT, set MemTimeout=1 at that edge. It clears only on Reset.
- MEM_WAIT with DMemBusy=0:
  - Clear busy counter.
  - Evaluate branch and load-use exactly as in RUN, in the same cycle.
- BranchTaken_MEM=1 and DMemBusy=0:
  - Outputs: FlushIFID=FlushIDEX=FlushEXMEM=1, PCSrc=1, PCWrite=1.
  - Load-use ignored; FlushCount += 1; next state RUN.
- Load-use hazard in RUN (or in MEM_WAIT after busy drops):
  - Outputs: PCWrite=0, IFIDWrite=0, IDEXBubble=1.
  - StallCycles += 1; next state LU_STALL.
- LU_STALL: hazard check suppressed, normal outputs, next state RUN (unless DMemBusy or branch applies). One bubble per load-use.
- Counters saturate at all-ones and never wrap.
- Reset values: state RUN; StallCycles=0, FlushCount=0, MemTimeout=0, busy counter=0.
- Reset has no effect on the combinational outputs in the reset cycle beyond using state=RUN.
- Reset mid-MEM_WAIT or mid-LU_STALL returns to RUN and zeroes everything at that edge.
- X on InstrID when IF/ID holds a flushed NOP (all zeros): decodes as R-type with Rn=Rm=0. A stall in that case is acceptable.

Test Plan:
- Load-use, R-type: MemRead_EX=1, Rd_EX=2, InstrID=0x8B040043 (ADD X3,X2,X4).
  - Required: PCWrite=0, IFIDWrite=0, IDEXBubble=1 for exactly one cycle, then RUN; StallCycles=1.
- XZR and no-source cases:
  - Rd_EX=31, InstrID=0x8B0403E3: no stall.
  - Rd_EX=0, InstrID=0x14000010 (B): no stall.
  - Rd_EX=5, InstrID=0xB4000085 (CBZ X5): one-cycle stall.
- Branch wins over hazard: BranchTaken_MEM=1 while the first scenario's hazard is present.
  - Required: all three flushes=1, PCSrc=1, IDEXBubble=0, FlushCount=1, StallCycles unchanged.
- Memory busy: DMemBusy=1 for 3 cycles, then 0.
  - Required: PipeHold=1, PCWrite=0 for 3 cycles; StallCycles=3; MemTimeout=0.
- Timeout, MEM_TIMEOUT=4: DMemBusy held 6 cycles.
  - Required: MemTimeout=1 after the 4th busy edge, still 1 after busy drops; Reset clears it.
- Reset during MEM_WAIT with DMemBusy=1:
  - Required: next cycle state RUN, counters=0; outputs follow DMemBusy again afterwards.
- Counter saturation, CNT_W=2: 5 flushes.
  - Required: FlushCount=3, no wrap.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the hazard controller and the LEGv8 pipeline registers.
// The pipeline side uses the master modport; the controller uses the slave modport.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [31:0]      InstrID;
   logic             MemRead_EX;
   logic [4:0]       Rd_EX;
   logic             BranchTaken_MEM;
   logic             DMemBusy;
   logic             PCWrite;
   logic             IFIDWrite;
   logic             IDEXBubble;
   logic             PipeHold;
   logic             FlushIFID;
   logic             FlushIDEX;
   logic             FlushEXMEM;
   logic             PCSrc;
   logic [CNT_W-1:0] StallCycles;
   logic [CNT_W-1:0] FlushCount;
   logic             MemTimeout;

   modport master (
      output InstrID, MemRead_EX, Rd_EX, BranchTaken_MEM, DMemBusy,
      input  PCWrite, IFIDWrite, IDEXBubble, PipeHold,
      input  FlushIFID, FlushIDEX, FlushEXMEM, PCSrc,
      input  StallCycles, FlushCount, MemTimeout
   );

   modport slave (
      input  InstrID, MemRead_EX, Rd_EX, BranchTaken_MEM, DMemBusy,
      output PCWrite, IFIDWrite, IDEXBubble, PipeHold,
      output FlushIFID, FlushIDEX, FlushEXMEM, PCSrc,
      output StallCycles, FlushCount, MemTimeout
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage LEGv8 pipeline: load-use bubbles,
// taken-branch flushes, data-memory freeze, saturating counters and a sticky timeout.
module pipeline_hazard_ctrl #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 255,
   parameter int TO_W        = 8
) (
   input  logic                  CLK,
   input  logic                  Reset,
   pipeline_hazard_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(MEM_TIMEOUT - 1);
   localparam logic [TO_W-1:0]  TO_MAX  = {TO_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // ADDI, ADDIS, SUBI, SUBIS, ANDI, ANDIS, ORRI, EORI opcodes in [31:22]
   localparam int N_IOPS = 8;
   localparam logic [9:0] I_OPS [N_IOPS] = '{
      10'b1001000100, 10'b1011000100, 10'b1101000100, 10'b1111000100,
      10'b1001001000, 10'b1111001000, 10'b1011001000, 10'b1101001000
   };

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
   logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;
   logic [TO_W-1:0]  busy_cnt_reg, busy_cnt_next;
   logic             timeout_reg, timeout_next;

   logic [10:0]       op11;
   logic [4:0]        rn, rm, rt;
   logic              is_lsl, is_ldur, is_stur, is_cb, is_b, is_itype;
   logic [N_IOPS-1:0] iop_match;
   logic              rn_valid, rm_valid, rt_valid;
   logic              hazard;

   logic pc_write, ifid_write, idex_bubble, pipe_hold;
   logic flush_all, pc_src;
   logic stall_inc, flush_inc;

   assign op11 = bus.InstrID[31:21];
   assign rn   = bus.InstrID[9:5];
   assign rm   = bus.InstrID[20:16];
   assign rt   = bus.InstrID[4:0];

   assign is_lsl  = (op11 == 11'b11010011011);
   assign is_ldur = (op11 == 11'b11111000010);
   assign is_stur = (op11 == 11'b11111000000);
   assign is_cb   = (bus.InstrID[31:24] == 8'b10110100) || (bus.InstrID[31:24] == 8'b10110101);
   assign is_b    = (bus.InstrID[31:26] == 6'b000101) || (bus.InstrID[31:26] == 6'b100101);

   genvar gi;
   generate
      for (gi = 0; gi < N_IOPS; gi++) begin : g_iop
         assign iop_match[gi] = (bus.InstrID[31:22] == I_OPS[gi]);
      end
   endgenerate
   assign is_itype = |iop_match;

   // R-type is the fall-through class, so a flushed all-zero IF/ID reads Rn=Rm=X0.
   always_comb begin
      rn_valid = 1'b1;
      rm_valid = 1'b1;
      rt_valid = 1'b0;
      if (is_lsl || is_ldur) begin
         rm_valid = 1'b0;
      end else if (is_stur) begin
         rm_valid = 1'b0;
         rt_valid = 1'b1;
      end else if (is_cb) begin
         rn_valid = 1'b0;
         rm_valid = 1'b0;
         rt_valid = 1'b1;
      end else if (is_b) begin
         rn_valid = 1'b0;
         rm_valid = 1'b0;
      end else if (is_itype) begin
         rm_valid = 1'b0;
      end
   end

   assign hazard = bus.MemRead_EX && (bus.Rd_EX != 5'd31) &&
                   ((rn_valid && (bus.Rd_EX == rn)) ||
                    (rm_valid && (bus.Rd_EX == rm)) ||
                    (rt_valid && (bus.Rd_EX == rt)));

   always_comb begin
      pc_write      = 1'b1;
      ifid_write    = 1'b1;
      idex_bubble   = 1'b0;
      pipe_hold     = 1'b0;
      flush_all     = 1'b0;
      pc_src        = 1'b0;
      stall_inc     = 1'b0;
      flush_inc     = 1'b0;
      state_next    = RUN;
      busy_cnt_next = '0;
      timeout_next  = timeout_reg;

      if (bus.DMemBusy) begin
         pc_write      = 1'b0;
         ifid_write    = 1'b0;
         pipe_hold     = 1'b1;
         stall_inc     = 1'b1;
         state_next    = MEM_WAIT;
         busy_cnt_next = (busy_cnt_reg == TO_MAX) ? busy_cnt_reg : busy_cnt_reg + TO_W'(1);
         if (busy_cnt_reg >= TO_LAST) begin
            timeout_next = 1'b1;
         end
      end else if (bus.BranchTaken_MEM) begin
         flush_all = 1'b1;
         pc_src    = 1'b1;
         flush_inc = 1'b1;
      end else if ((state_reg != LU_STALL) && hazard) begin
         // Leaving MEM_WAIT takes this path too, so a hazard waiting behind the freeze still bubbles.
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
         stall_inc   = 1'b1;
         state_next  = LU_STALL;
      end

      stall_cnt_next = (stall_inc && (stall_cnt_reg != CNT_MAX)) ?
                       stall_cnt_reg + CNT_W'(1) : stall_cnt_reg;
      flush_cnt_next = (flush_inc && (flush_cnt_reg != CNT_MAX)) ?
                       flush_cnt_reg + CNT_W'(1) : flush_cnt_reg;
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_reg     <= RUN;
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
         busy_cnt_reg  <= '0;
         timeout_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         stall_cnt_reg <= stall_cnt_next;
         flush_cnt_reg <= flush_cnt_next;
         busy_cnt_reg  <= busy_cnt_next;
         timeout_reg   <= timeout_next;
      end
   end

   assign bus.PCWrite     = pc_write;
   assign bus.IFIDWrite   = ifid_write;
   assign bus.IDEXBubble  = idex_bubble;
   assign bus.PipeHold    = pipe_hold;
   assign bus.FlushIFID   = flush_all;
   assign bus.FlushIDEX   = flush_all;
   assign bus.FlushEXMEM  = flush_all;
   assign bus.PCSrc       = pc_src;
   assign bus.StallCycles = stall_cnt_reg;
   assign bus.FlushCount  = flush_cnt_reg;
   assign bus.MemTimeout  = timeout_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: one instance with a short memory timeout,
// one with 2-bit counters for saturation.
module tb_pipeline_hazard_ctrl;

   logic clk = 1'b0;
   logic reset_a, reset_b;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.CNT_W(16)) bus_a ();
   pipeline_hazard_ctrl_if #(.CNT_W(2))  bus_b ();

   pipeline_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(4), .TO_W(8)) dut_a (
      .CLK   (clk),
      .Reset (reset_a),
      .bus   (bus_a.slave)
   );

   pipeline_hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(255), .TO_W(8)) dut_b (
      .CLK   (clk),
      .Reset (reset_b),
      .bus   (bus_b.slave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic [31:0] instr, input logic memrd, input logic [4:0] rd,
                          input logic br, input logic busy);
      bus_a.InstrID         = instr;
      bus_a.MemRead_EX      = memrd;
      bus_a.Rd_EX           = rd;
      bus_a.BranchTaken_MEM = br;
      bus_a.DMemBusy        = busy;
      #1;
   endtask

   initial begin
      reset_a = 1'b1;
      reset_b = 1'b1;
      drive_a(32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
      bus_b.InstrID         = 32'h0;
      bus_b.MemRead_EX      = 1'b0;
      bus_b.Rd_EX           = 5'd0;
      bus_b.BranchTaken_MEM = 1'b0;
      bus_b.DMemBusy        = 1'b0;
      repeat (2) tick();
      reset_a = 1'b0;
      reset_b = 1'b0;
      #1;

      check("reset_stall", bus_a.StallCycles, 0);
      check("reset_flush", bus_a.FlushCount, 0);
      check("reset_timeout", bus_a.MemTimeout, 0);
      check("reset_pcwrite", bus_a.PCWrite, 1);

      // Load-use on ADD X3,X2,X4 with LDUR X2 in EX
      drive_a(32'h8B040043, 1'b1, 5'd2, 1'b0, 1'b0);
      check("lu_pcwrite", bus_a.PCWrite, 0);
      check("lu_ifidwrite", bus_a.IFIDWrite, 0);
      check("lu_bubble", bus_a.IDEXBubble, 1);
      tick();
      check("lu_stall_bubble", bus_a.IDEXBubble, 0);
      check("lu_stall_pcwrite", bus_a.PCWrite, 1);
      check("lu_stallcycles", bus_a.StallCycles, 1);
      tick();
      drive_a(32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
      check("lu_after_stall", bus_a.StallCycles, 1);

      drive_a(32'h8B0403E3, 1'b1, 5'd31, 1'b0, 1'b0);
      check("xzr_bubble", bus_a.IDEXBubble, 0);
      check("xzr_pcwrite", bus_a.PCWrite, 1);
      drive_a(32'h14000010, 1'b1, 5'd0, 1'b0, 1'b0);
      check("b_bubble", bus_a.IDEXBubble, 0);
      drive_a(32'hB4000085, 1'b1, 5'd5, 1'b0, 1'b0);
      check("cbz_bubble", bus_a.IDEXBubble, 1);
      tick();
      check("cbz_stall_bubble", bus_a.IDEXBubble, 0);
      check("cbz_stallcycles", bus_a.StallCycles, 2);
      tick();
      drive_a(32'h0, 1'b0, 5'd0, 1'b0, 1'b0);

      // Branch wins over the same load-use hazard
      drive_a(32'h8B040043, 1'b1, 5'd2, 1'b1, 1'b0);
      check("br_flushifid", bus_a.FlushIFID, 1);
      check("br_flushidex", bus_a.FlushIDEX, 1);
      check("br_flushexmem", bus_a.FlushEXMEM, 1);
      check("br_pcsrc", bus_a.PCSrc, 1);
      check("br_bubble", bus_a.IDEXBubble, 0);
      check("br_pcwrite", bus_a.PCWrite, 1);
      tick();
      drive_a(32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
      check("br_flushcount", bus_a.FlushCount, 1);
      check("br_stallcycles", bus_a.StallCycles, 2);

      // Data memory busy for three cycles
      for (int i = 0; i < 3; i++) begin
         drive_a(32'h0, 1'b0, 5'd0, 1'b0, 1'b1);
         check($sformatf("busy%0d_pipehold", i), bus_a.PipeHold, 1);
         check($sformatf("busy%0d_pcwrite", i), bus_a.PCWrite, 0);
         tick();
      end
      drive_a(32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
      check("busy_stallcycles", bus_a.StallCycles, 5);
      check("busy_timeout", bus_a.MemTimeout, 0);
      check("busy_release_hold", bus_a.PipeHold, 0);
      check("busy_release_pcwrite", bus_a.PCWrite, 1);
      tick();

      // Timeout after the 4th consecutive busy edge, sticky afterwards
      drive_a(32'h0, 1'b0, 5'd0, 1'b0, 1'b1);
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (i == 3) check("to_after3", bus_a.MemTimeout, 0);
         if (i == 4) check("to_after4", bus_a.MemTimeout, 1);
      end
      drive_a(32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
      check("to_stallcycles", bus_a.StallCycles, 11);
      tick();
      check("to_sticky", bus_a.MemTimeout, 1);

      // Hazard seen in the same cycle busy drops out of MEM_WAIT
      drive_a(32'h0, 1'b0, 5'd0, 1'b0, 1'b1);
      tick();
      drive_a(32'h8B040043, 1'b1, 5'd2, 1'b0, 1'b0);
      check("mw_lu_bubble", bus_a.IDEXBubble, 1);
      tick();
      drive_a(32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();
      check("mw_lu_stallcycles", bus_a.StallCycles, 13);

      // Reset during MEM_WAIT with busy still asserted
      drive_a(32'h0, 1'b0, 5'd0, 1'b0, 1'b1);
      tick();
      reset_a = 1'b1;
      #1;
      check("rst_mw_hold_in_reset", bus_a.PipeHold, 1);
      tick();
      reset_a = 1'b0;
      #1;
      check("rst_mw_stall", bus_a.StallCycles, 0);
      check("rst_mw_flush", bus_a.FlushCount, 0);
      check("rst_mw_timeout", bus_a.MemTimeout, 0);
      check("rst_mw_hold_after", bus_a.PipeHold, 1);
      drive_a(32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
      check("rst_mw_release_hold", bus_a.PipeHold, 0);
      check("rst_mw_release_pcwrite", bus_a.PCWrite, 1);
      tick();

      // Reset during LU_STALL: hazard checking resumes immediately
      drive_a(32'h8B040043, 1'b1, 5'd2, 1'b0, 1'b0);
      tick();
      reset_a = 1'b1;
      #1;
      check("rst_lu_bubble_in_reset", bus_a.IDEXBubble, 0);
      tick();
      reset_a = 1'b0;
      #1;
      check("rst_lu_stall", bus_a.StallCycles, 0);
      check("rst_lu_bubble_after", bus_a.IDEXBubble, 1);
      drive_a(32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();

      // 2-bit flush counter saturates at 3
      bus_b.BranchTaken_MEM = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         check($sformatf("sat_flush%0d", i), bus_b.FlushCount, (i < 3) ? i : 3);
      end
      bus_b.BranchTaken_MEM = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
